user_input_debounce: RTL and testbench

- Memory-mapped user-input peripheral that conditions the board's 64 DIP switches and 8 push keys.
- Provides a 2-flop synchronizer, shared-tick debounce and change detection.
- Drives the debounced 64-bit switch word straight into the digital-tube display block (A = high word, B = low word) and exposes all state on the CPU bus.
- Raises a maskable interrupt on any debounced change. Sits between board pins and the display/bridge.

---
 rtl/user_input_debounce.sv | 130 +++++++++++++
 tb/tb_user_input_debounce.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_input_debounce.sv
// User-input peripheral: synchronizes and debounces 64 DIP switches and NKEY
// push keys, drives the debounced switch word to the display, and exposes
// state plus a maskable change interrupt on a small word-addressed bus.
module user_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned NKEY            = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [63:0]     sw_raw,
  input  logic [NKEY-1:0] key_raw,
  input  logic [1:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  output logic [31:0]     A,
  output logic [31:0]     B,
  output logic            irq
);

  localparam int unsigned SW_W  = 64;
  localparam int unsigned IN_W  = NKEY + SW_W;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] ADDR_SW_LO = 2'd0;
  localparam logic [1:0] ADDR_SW_HI = 2'd1;
  localparam logic [1:0] ADDR_KEY   = 2'd2;
  localparam logic [1:0] ADDR_CTL   = 2'd3;

  logic [IN_W-1:0]  sync1;
  logic [IN_W-1:0]  s;
  logic [IN_W-1:0]  prev_sample;
  logic [IN_W-1:0]  db;
  logic [IN_W-1:0]  diff_c;
  logic [IN_W-1:0]  db_next_c;
  logic [CNT_W-1:0] cnt;
  logic             tick_c;
  logic             change_c;
  logic             ctl_wr_c;
  logic             pending;
  logic             irq_en;
  logic [NKEY-1:0]  key_db;
  logic [SW_W-1:0]  sw_db;
  logic             din_unused_c;

  assign tick_c       = (cnt == '0);
  assign ctl_wr_c     = WE && (Addr == ADDR_CTL);
  assign key_db       = db[IN_W-1:SW_W];
  assign sw_db        = db[SW_W-1:0];
  assign din_unused_c = ^din[31:2];

  // Shared sample-tick down-counter, reloads on reaching zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CNT_RELOAD;
    end else if (tick_c) begin
      cnt <= CNT_RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Two-flop synchronizer on all raw pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= {key_raw, sw_raw};
      s     <= sync1;
    end
  end

  // Per-bit qualification: a bit follows s only when two consecutive ticks agree
  always_comb begin
    diff_c    = s ^ prev_sample;
    db_next_c = db;
    if (tick_c) begin
      db_next_c = (s & ~diff_c) | (db & diff_c);
    end
    change_c = (db_next_c != db);
  end

  // Tick-sampled history and debounced state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sample <= '0;
      db          <= '0;
    end else begin
      if (tick_c) begin
        prev_sample <= s;
      end
      db <= db_next_c;
    end
  end

  // Interrupt control: change sets pending and beats a simultaneous W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      irq_en  <= 1'b0;
    end else begin
      if (change_c) begin
        pending <= 1'b1;
      end else if (ctl_wr_c && din[1]) begin
        pending <= 1'b0;
      end
      if (ctl_wr_c) begin
        irq_en <= din[0];
      end
    end
  end

  // Bus read mux straight from registers
  always_comb begin
    dout = '0;
    case (Addr)
      ADDR_SW_LO: dout = sw_db[31:0];
      ADDR_SW_HI: dout = sw_db[63:32];
      ADDR_KEY:   dout = 32'(key_db);
      ADDR_CTL:   dout = {30'd0, pending, irq_en};
      default:    dout = '0;
    endcase
  end

  assign A   = sw_db[63:32];
  assign B   = sw_db[31:0];
  assign irq = irq_en & pending;

endmodule

// File: tb/tb_user_input_debounce.sv
// Scoreboard bench for user_input_debounce with DEBOUNCE_CYCLES=4, NKEY=8.
module tb_user_input_debounce;

  localparam int unsigned DC = 4;
  localparam int unsigned NK = 8;

  localparam int K_DOUT = 0;
  localparam int K_A    = 1;
  localparam int K_B    = 2;
  localparam int K_IRQ  = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_entry_t;

  logic          clk;
  logic          reset;
  logic [63:0]   sw_raw;
  logic [NK-1:0] key_raw;
  logic [1:0]    Addr;
  logic          WE;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic [31:0]   A;
  logic [31:0]   B;
  logic          irq;

  sb_entry_t sb[$];
  logic      chk_valid;
  int        checks;
  int        fails;
  int        ecnt;

  user_input_debounce #(.DEBOUNCE_CYCLES(DC), .NKEY(NK)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .key_raw(key_raw),
    .Addr(Addr), .WE(WE), .din(din), .dout(dout), .A(A), .B(B), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release; ticks land on edges where ecnt%4==0
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // Monitor: pops an expectation whenever a check is presented
  always @(negedge clk) begin
    if (chk_valid) begin
      sb_entry_t   e;
      logic [31:0] obs;
      checks = checks + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL scoreboard_underflow: no expectation queued");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          K_A:     obs = A;
          K_B:     obs = B;
          K_IRQ:   obs = {31'd0, irq};
          default: obs = dout;
        endcase
        if (obs !== e.exp) begin
          fails = fails + 1;
          $display("FAIL %s: got %h expected %h (t=%0t)", e.name, obs, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expectation and present it for one cycle
  task automatic chk(input int kind, input logic [1:0] a, input logic [31:0] exp,
                     input string name);
    sb_entry_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    Addr   = a;
    sb.push_back(e);
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    din  = '0;
  endtask

  task automatic align(input int r);
    for (int i = 0; i < 8; i++) begin
      if ((ecnt % 4) == r) break;
      cyc(1);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    chk_valid = 1'b0;
    reset     = 1'b0;
    sw_raw    = 64'hFFFF_FFFF_FFFF_FFFF;
    key_raw   = '0;
    Addr      = 2'd0;
    WE        = 1'b0;
    din       = '0;

    // 1: reset with all switches high, then qualification after two ticks
    cyc(2);
    chk(K_A,    2'd0, 32'h0, "rst_A");
    chk(K_B,    2'd0, 32'h0, "rst_B");
    chk(K_IRQ,  2'd0, 32'h0, "rst_irq");
    chk(K_DOUT, 2'd3, 32'h0, "rst_ctl");
    chk(K_DOUT, 2'd0, 32'h0, "rst_sw_lo");
    reset = 1'b1;
    cyc(5);
    chk(K_A,    2'd0, 32'h0, "pre_qual_A_e5");
    cyc(1);
    chk(K_B,    2'd0, 32'h0, "pre_qual_B_e7");
    chk(K_A,    2'd0, 32'hFFFF_FFFF, "qual_A_e8");
    chk(K_B,    2'd0, 32'hFFFF_FFFF, "qual_B");
    chk(K_DOUT, 2'd3, 32'h2, "qual_ctl_pending");
    chk(K_IRQ,  2'd0, 32'h0, "qual_irq_disabled");

    // 2: stable change on sw_raw[3:0]
    sw_raw = 64'h0;
    cyc(12);
    chk(K_B, 2'd0, 32'h0, "clear_B");
    chk(K_A, 2'd0, 32'h0, "clear_A");
    bus_write(2'd3, 32'h2);
    chk(K_DOUT, 2'd3, 32'h0, "w1c_pending");
    sw_raw = 64'h0000_0000_0000_000A;
    cyc(11);
    chk(K_B,    2'd0, 32'h0000_000A, "stable_B");
    chk(K_DOUT, 2'd0, 32'h0000_000A, "stable_rd0");
    chk(K_A,    2'd0, 32'h0, "stable_A_unchanged");
    chk(K_DOUT, 2'd1, 32'h0, "stable_rd1");

    // 3: key glitch straddling a single tick is rejected
    bus_write(2'd3, 32'h2);
    align(1);
    key_raw = 8'h01;
    cyc(2);
    key_raw = 8'h00;
    cyc(12);
    chk(K_DOUT, 2'd2, 32'h0, "glitch_key");
    chk(K_DOUT, 2'd3, 32'h0, "glitch_pending");

    // 4: interrupt enable, clear, disable
    bus_write(2'd3, 32'h3);
    key_raw = 8'h81;
    cyc(11);
    chk(K_DOUT, 2'd2, 32'h81, "irq_key");
    chk(K_IRQ,  2'd0, 32'h1, "irq_set");
    chk(K_DOUT, 2'd3, 32'h3, "irq_ctl");
    bus_write(2'd3, 32'h3);
    chk(K_IRQ,  2'd0, 32'h0, "irq_w1c");
    chk(K_DOUT, 2'd3, 32'h1, "irq_w1c_ctl");
    key_raw = 8'h00;
    cyc(11);
    chk(K_IRQ,  2'd0, 32'h1, "irq_reassert");
    bus_write(2'd3, 32'h0);
    chk(K_IRQ,  2'd0, 32'h0, "irq_disabled");
    chk(K_DOUT, 2'd3, 32'h2, "disable_keeps_pending");

    // 5: W1C lands on the same edge sw_db changes -- set wins
    bus_write(2'd3, 32'h3);
    align(3);
    sw_raw = 64'h1234_5678_0000_000A;
    cyc(8);
    bus_write(2'd3, 32'h3);
    chk(K_DOUT, 2'd3, 32'h3, "collide_ctl");
    chk(K_IRQ,  2'd0, 32'h1, "collide_irq");
    chk(K_A,    2'd0, 32'h1234_5678, "collide_A");

    // 6: async reset one cycle after the first tick sees a new value
    align(3);
    sw_raw = 64'h0000_0000_DEAD_BEEF;
    cyc(6);
    reset = 1'b0;
    chk(K_A,    2'd0, 32'h0, "async_A");
    chk(K_B,    2'd0, 32'h0, "async_B");
    chk(K_IRQ,  2'd0, 32'h0, "async_irq");
    chk(K_DOUT, 2'd3, 32'h0, "async_ctl");
    reset = 1'b1;
    cyc(7);
    chk(K_B,    2'd0, 32'h0, "requal_B_e7");
    chk(K_B,    2'd0, 32'hDEAD_BEEF, "requal_B_e8");
    chk(K_A,    2'd0, 32'h0, "requal_A");
    chk(K_DOUT, 2'd3, 32'h2, "requal_ctl");
    chk(K_IRQ,  2'd0, 32'h0, "requal_irq");

    cyc(2);
    checks = checks + 1;
    if (sb.size() != 0) begin
      fails = fails + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
